instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit_pkg.sv | 25 ++
 rtl/instr_fetch_unit_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared datapath definitions: opcode encodings and the fetch FSM state type.
package instr_fetch_unit_pkg;

  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4,
    OP_SLT = 6'd5,
    OP_LW  = 6'd6,
    OP_SW  = 6'd7,
    OP_JMP = 6'd8,
    OP_BEQ = 6'd9,
    OP_BNE = 6'd10
  } opcode_e;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries; flush wins over push/pop.
module ifu_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC ownership, credit-limited imem requests, decode buffer, redirects.
// Build option IFU_NOP_DROP_EN: returning opcode-0 words are dropped instead of buffered.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INSTR_W    = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_rd_en,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [ADDR_W-1:0]   id_pc,
  output logic [OPCODE_W-1:0] id_opcode,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   issue_pc_q, issue_pc_d;
  logic                inflight_q, inflight_d;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                credit_ok_c;
  logic                keep_word_c;
  logic                push_c;
  logic                pop_c;

`ifdef IFU_NOP_DROP_EN
  assign keep_word_c = imem_rdata[INSTR_W-1 -: OPCODE_W] != OPCODE_W'(OP_NOP);
`else
  assign keep_word_c = 1'b1;
`endif

  // Credit uses registered occupancy only; a pop this cycle frees nothing until next cycle.
  assign credit_ok_c = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    imem_rd_en = 1'b0;
    inflight_d = 1'b0;
    push_c     = 1'b0;
    pop_c      = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        state_d    = ST_RUN;
        imem_rd_en = !redirect_valid && credit_ok_c;
      end
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (imem_rd_en) begin
      pc_d       = pc_q + ADDR_W'(4);
      issue_pc_d = pc_q;
    end

    inflight_d = imem_rd_en;
    // A redirect squashes the returning word and voids any pop in the same cycle.
    push_c     = inflight_q && !redirect_valid && keep_word_c;
    pop_c      = id_valid && id_ready && !redirect_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
    end
  end

  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data ({issue_pc_q, imem_rdata}),
    .pop       (pop_c),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign imem_addr = pc_q;
  assign id_valid  = fifo_count != '0;
  assign id_instr  = fifo_head[INSTR_W-1:0];
  assign id_pc     = fifo_head[ENTRY_W-1:INSTR_W];
  assign id_opcode = fifo_head[INSTR_W-1 -: OPCODE_W];

endmodule
